fifo_drain_ctrl: RTL and testbench

//   Read-side controller for the pointer-only fifo (no full/empty flags). Snoops the

---
 rtl/fifo_drain_ctrl.sv | 79 +++++++
 tb/tb_fifo_drain_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for a flagless pointer fifo: it tracks occupancy from the write strobe,
// issues read strobes, and presents each word on a registered valid/ready output.
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_SIZE  = 3,
    parameter int CNT_WIDTH  = $clog2(FIFO_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  signal_wr,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  signal_oe,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    input  logic                  clr_ovf
);

    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(FIFO_SIZE);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  vld_q, vld_d;

    // The fifo ignores a read that coincides with a write, so a read is never issued then.
    assign signal_oe = enable & (count_q != '0) & ~signal_wr & (~vld_q | m_ready);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        vld_d   = vld_q;

        // Clear first so that a same-cycle overflow event takes precedence.
        if (clr_ovf)
            ovf_d = 1'b0;

        if (signal_wr) begin
            if (count_q != FULL)
                count_d = count_q + ONE;
            else
                ovf_d = 1'b1;
        end else if (signal_oe) begin
            count_d = count_q - ONE;
        end

        if (signal_oe) begin
            data_d = fifo_data;
            vld_d  = 1'b1;
        end else if (vld_q && m_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;
    assign m_data   = data_q;
    assign m_valid  = vld_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl, with a behavioural 3-deep pointer fifo on its read port.
module tb_fifo_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        signal_wr;
    logic [31:0] wdata;
    logic [31:0] fifo_data;
    logic        signal_oe;
    logic        enable;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  count;
    logic        overflow;
    logic        clr_ovf;

    int passes = 0;
    int total  = 0;
    int oe_cnt;

    always #5 clk = ~clk;

    fifo_drain_ctrl #(.DATA_WIDTH(32), .FIFO_SIZE(3)) dut (
        .clk(clk), .rst_n(rst_n), .signal_wr(signal_wr), .fifo_data(fifo_data),
        .signal_oe(signal_oe), .enable(enable), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    // Pointer-only fifo: write wins, data_out is the word at the read pointer.
    logic [31:0] mem [3] = '{32'h0, 32'h0, 32'h0};
    int wp = 0, rp = 0;
    assign fifo_data = mem[rp];
    always @(posedge clk) begin
        if (!rst_n) begin
            wp <= 0;
            rp <= 0;
        end else if (signal_wr) begin
            mem[wp] <= wdata;
            wp <= (wp == 2) ? 0 : wp + 1;
        end else if (signal_oe) begin
            rp <= (rp == 2) ? 0 : rp + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic v, input logic [1:0] c);
        chk({tag, ".m_data"}, 64'(m_data), 64'(d));
        chk({tag, ".m_valid"}, 64'(m_valid), 64'(v));
        chk({tag, ".count"}, 64'(count), 64'(c));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; signal_wr = 1'b0; wdata = '0; enable = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
        cyc(); cyc();
        chk_out("reset", 32'h0, 1'b0, 2'd0);
        chk("reset.overflow", 64'(overflow), 64'd0);
        chk("reset.oe", 64'(signal_oe), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Stream: three back-to-back writes then three back-to-back reads.
        enable = 1'b1; m_ready = 1'b1;
        signal_wr = 1'b1; wdata = 32'hA1; #1;
        chk("stream.oe_w1", 64'(signal_oe), 64'd0);
        cyc(); chk("stream.cnt1", 64'(count), 64'd1);
        wdata = 32'hA2; #1;
        chk("stream.oe_w2", 64'(signal_oe), 64'd0);
        cyc(); chk("stream.cnt2", 64'(count), 64'd2);
        wdata = 32'hA3;
        cyc(); chk("stream.cnt3", 64'(count), 64'd3);
        signal_wr = 1'b0; #1;
        chk("stream.oe_r1", 64'(signal_oe), 64'd1);
        cyc(); chk_out("stream.r1", 32'hA1, 1'b1, 2'd2);
        chk("stream.oe_r2", 64'(signal_oe), 64'd1);
        cyc(); chk_out("stream.r2", 32'hA2, 1'b1, 2'd1);
        cyc(); chk_out("stream.r3", 32'hA3, 1'b1, 2'd0);
        chk("stream.oe_idle", 64'(signal_oe), 64'd0);
        cyc(); chk_out("stream.drained", 32'hA3, 1'b0, 2'd0);

        // Collision: writes while words are stored must suppress reads.
        signal_wr = 1'b1; wdata = 32'hB1;
        cyc(); chk("coll.cnt1", 64'(count), 64'd1);
        wdata = 32'hB2; #1;
        chk("coll.oe1", 64'(signal_oe), 64'd0);
        cyc();
        wdata = 32'hB3; #1;
        chk("coll.oe2", 64'(signal_oe), 64'd0);
        cyc(); chk("coll.cnt3", 64'(count), 64'd3);
        signal_wr = 1'b0;
        cyc(); chk_out("coll.r1", 32'hB1, 1'b1, 2'd2);
        cyc(); chk_out("coll.r2", 32'hB2, 1'b1, 2'd1);
        cyc(); chk_out("coll.r3", 32'hB3, 1'b1, 2'd0);
        cyc(); chk_out("coll.drained", 32'hB3, 1'b0, 2'd0);

        // Backpressure: only the first word is taken while the consumer stalls.
        m_ready = 1'b0; signal_wr = 1'b1;
        wdata = 32'hC1; cyc();
        wdata = 32'hC2; cyc();
        wdata = 32'hC3; cyc();
        signal_wr = 1'b0;
        chk("bp.full", 64'(count), 64'd3);
        oe_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (signal_oe) oe_cnt++;
            cyc();
        end
        chk("bp.oe_count", 64'(oe_cnt), 64'd1);
        chk_out("bp.held", 32'hC1, 1'b1, 2'd2);
        m_ready = 1'b1;
        cyc(); chk_out("bp.r2", 32'hC2, 1'b1, 2'd1);
        cyc(); chk_out("bp.r3", 32'hC3, 1'b1, 2'd0);
        cyc(); chk_out("bp.drained", 32'hC3, 1'b0, 2'd0);

        // Reset in mid-transfer with a word held and another stored.
        m_ready = 1'b0; signal_wr = 1'b1;
        wdata = 32'hD1; cyc();
        wdata = 32'hD2; cyc();
        signal_wr = 1'b0;
        cyc(); chk_out("rstmid.pre", 32'hD1, 1'b1, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("rstmid.async", 32'h0, 1'b0, 2'd0);
        chk("rstmid.oe", 64'(signal_oe), 64'd0);
        cyc(); cyc();
        rst_n = 1'b1; m_ready = 1'b1;
        cyc(); chk_out("rstmid.after", 32'h0, 1'b0, 2'd0);
        chk("rstmid.oe_after", 64'(signal_oe), 64'd0);

        // Wrap: ten single-word push/pop pairs walk the pointers round three times.
        for (int k = 0; k < 10; k++) begin
            signal_wr = 1'b1; wdata = 32'h100 + 32'(k);
            cyc();
            signal_wr = 1'b0;
            cyc();
            chk($sformatf("wrap.w%0d", k), 64'(m_data), 64'(32'h100 + 32'(k)));
        end
        cyc();
        chk_out("wrap.end", 32'h109, 1'b0, 2'd0);
        chk("wrap.ovf", 64'(overflow), 64'd0);

        // Overflow: reads disabled, a fourth write on a full fifo sets the sticky flag.
        enable = 1'b0; signal_wr = 1'b1;
        wdata = 32'hE0; cyc();
        wdata = 32'hE1; cyc();
        wdata = 32'hE2; cyc();
        chk("ovf.cnt3", 64'(count), 64'd3);
        chk("ovf.not_yet", 64'(overflow), 64'd0);
        wdata = 32'hE3; cyc();
        chk("ovf.set", 64'(overflow), 64'd1);
        chk("ovf.cnt_sat", 64'(count), 64'd3);
        signal_wr = 1'b0; #1;
        chk("ovf.oe_disabled", 64'(signal_oe), 64'd0);
        cyc();
        chk("ovf.sticky", 64'(overflow), 64'd1);
        clr_ovf = 1'b1; cyc();
        chk("ovf.cleared", 64'(overflow), 64'd0);
        signal_wr = 1'b1; wdata = 32'hE4; cyc();
        chk("ovf.set_wins", 64'(overflow), 64'd1);
        signal_wr = 1'b0; clr_ovf = 1'b0;
        cyc();
        chk("ovf.final_cnt", 64'(count), 64'd3);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
